// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: operation codes and FSM state encoding.
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHL  = 3'b001;
    localparam logic [2:0] USR_SHR  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROTL = 3'b100;
    localparam logic [2:0] USR_ROTR = 3'b101;
    localparam logic [2:0] USR_ASR  = 3'b110;
    localparam logic [2:0] USR_CLR  = 3'b111;

    localparam logic [0:0] USR_IDLE  = 1'b0;
    localparam logic [0:0] USR_SHIFT = 1'b1;

endpackage

// File: rtl/usr_step.sv
// Single-position step function of the shift register; purely combinational.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_step
);

    always_comb begin
        unique case (mode)
            USR_SHL:  q_step = {q[WIDTH-2:0], sin_l};
            USR_SHR:  q_step = {sin_r, q[WIDTH-1:1]};
            USR_LOAD: q_step = d;
            USR_ROTL: q_step = {q[WIDTH-2:0], q[WIDTH-1]};
            USR_ROTR: q_step = {q[0], q[WIDTH-1:1]};
            USR_ASR:  q_step = {q[WIDTH-1], q[WIDTH-1:1]};
            USR_CLR:  q_step = '0;
            default:  q_step = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_n.sv
// Parametrised universal shift register with single-step ops and an FSM-sequenced counted shift.
module universal_shift_register_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_r_q, mode_r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] q_step;

    // One step unit serves both paths: the live mode in IDLE, the latched mode in SHIFT.
    assign step_mode = (state_q == USR_SHIFT) ? mode_r_q : mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_q),
        .mode   (step_mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_step (q_step)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d  = state_q;
        rem_d    = rem_q;
        mode_r_d = mode_r_q;
        q_d      = q_q;
        done_d   = 1'b0;

        unique case (state_q)
            USR_IDLE: begin
                if (start) begin
                    mode_r_d = mode;
                    rem_d    = amt;
                    state_d  = USR_SHIFT;
                end else if (en) begin
                    q_d = q_step;
                end
            end
            default: begin
                if (rem_q == '0) begin
                    state_d = USR_IDLE;
                    done_d  = 1'b1;
                end else begin
                    q_d = q_step;
                    // Load and clear are idempotent, so they finish after a single step.
                    if (rem_q == CNT_W'(1) || mode_r_q == USR_LOAD || mode_r_q == USR_CLR) begin
                        rem_d   = '0;
                        state_d = USR_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= USR_IDLE;
            rem_q    <= '0;
            mode_r_q <= USR_HOLD;
            q_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            mode_r_q <= mode_r_d;
            q_q      <= q_d;
            done_q   <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == USR_SHIFT);
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Scoreboard bench for universal_shift_register_n at WIDTH=8: expected q/busy/done queued per edge.
module tb_universal_shift_register_n;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    universal_shift_register_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .mode   (mode),
        .amt    (amt),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
        exp_t e;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then compare the DUT against the oldest queued expectation.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_q"},      32'(q),      32'(e.q));
            check({tag, "_busy"},   32'(busy),   32'(e.busy));
            check({tag, "_done"},   32'(done),   32'(e.done));
            check({tag, "_sout_l"}, 32'(sout_l), 32'(e.q[WIDTH-1]));
            check({tag, "_sout_r"}, 32'(sout_r), 32'(e.q[0]));
        end
    endtask

    task automatic single(input string tag, input logic [2:0] m, input logic [WIDTH-1:0] dv,
                          input logic sl, input logic sr, input logic [WIDTH-1:0] exp_q);
        en    = 1'b1;
        mode  = m;
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        push(exp_q, 1'b0, 1'b0);
        tick(tag);
        en = 1'b0;
    endtask

    task automatic kick(input string tag, input logic [2:0] m, input logic [CNT_W-1:0] n,
                        input logic [WIDTH-1:0] q_now);
        start = 1'b1;
        mode  = m;
        amt   = n;
        push(q_now, 1'b1, 1'b0);
        tick(tag);
        start = 1'b0;
        mode  = USR_HOLD;
        amt   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] rv;
        reset = 1'b1; en = 1'b0; start = 1'b0; mode = USR_HOLD; amt = '0;
        d = '0; sin_l = 1'b0; sin_r = 1'b0;

        // Reset with q preloaded
        push(8'h00, 1'b0, 1'b0); tick("rst_init");
        reset = 1'b0;
        single("preload", USR_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5);
        reset = 1'b1;
        push(8'h00, 1'b0, 1'b0); tick("rst1");
        push(8'h00, 1'b0, 1'b0); tick("rst2");
        reset = 1'b0;

        // Single-step modes from 1001_0110
        single("ld96", USR_LOAD, 8'h96, 1'b0, 1'b0, 8'h96);
        single("shl",  USR_SHL,  8'h00, 1'b1, 1'b0, 8'h2D);
        single("ld96", USR_LOAD, 8'h96, 1'b0, 1'b0, 8'h96);
        single("shr",  USR_SHR,  8'h00, 1'b1, 1'b0, 8'h4B);
        single("ld96", USR_LOAD, 8'h96, 1'b0, 1'b0, 8'h96);
        single("rotl", USR_ROTL, 8'h00, 1'b0, 1'b1, 8'h2D);
        single("ld96", USR_LOAD, 8'h96, 1'b0, 1'b0, 8'h96);
        single("rotr", USR_ROTR, 8'h00, 1'b1, 1'b1, 8'h4B);
        single("ld96", USR_LOAD, 8'h96, 1'b0, 1'b0, 8'h96);
        single("asr",  USR_ASR,  8'h00, 1'b0, 1'b0, 8'hCB);
        single("hold", USR_HOLD, 8'h55, 1'b1, 1'b1, 8'hCB);
        single("clr",  USR_CLR,  8'h00, 1'b1, 1'b1, 8'h00);
        single("ld3c", USR_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C);
        push(8'h3C, 1'b0, 1'b0); tick("idle_hold");

        // Counted rotr by 3 on 0x81; en asserted at start and during busy must not step q
        single("ld81", USR_LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
        en = 1'b1;
        kick("rotr3_start", USR_ROTR, 4'd3, 8'h81);
        mode = USR_CLR;
        push(8'hC0, 1'b1, 1'b0); tick("rotr3_s1");
        push(8'h60, 1'b1, 1'b0); tick("rotr3_s2");
        en = 1'b0;
        push(8'h30, 1'b0, 1'b1); tick("rotr3_s3");
        push(8'h30, 1'b0, 1'b0); tick("rotr3_after");
        mode = USR_HOLD;

        // Zero count: done after two edges, q unchanged
        single("ld5a", USR_LOAD, 8'h5A, 1'b0, 1'b0, 8'h5A);
        kick("amt0_start", USR_SHL, 4'd0, 8'h5A);
        push(8'h5A, 1'b0, 1'b1); tick("amt0_done");
        push(8'h5A, 1'b0, 1'b0); tick("amt0_after");

        // rotl by 9 wraps to a single-position rotate
        single("ld01", USR_LOAD, 8'h01, 1'b0, 1'b0, 8'h01);
        kick("rotl9_start", USR_ROTL, 4'd9, 8'h01);
        for (int i = 1; i <= 9; i++) begin
            rv = 8'h01 << (i % 8);
            push(rv, (i < 9), (i == 9));
            tick("rotl9_step");
        end
        check("rotl9_final", 32'(q), 32'h02);

        // asr by 8 saturates to the sign bit
        single("ld80", USR_LOAD, 8'h80, 1'b0, 1'b0, 8'h80);
        kick("asr8_start", USR_ASR, 4'd8, 8'h80);
        for (int i = 1; i <= 8; i++) begin
            rv = ~(8'hFF >> (i + 1));
            push(rv, (i < 8), (i == 8));
            tick("asr8_step");
        end
        check("asr8_final", 32'(q), 32'hFF);

        // Counted load ignores a large amt and finishes after one step
        kick("load5_start", USR_LOAD, 4'd5, 8'hFF);
        d = 8'hAA;
        push(8'hAA, 1'b0, 1'b1); tick("load5_done");
        push(8'hAA, 1'b0, 1'b0); tick("load5_after");

        // Serial shift-in with live sin_l sampled at each step
        single("clr0", USR_CLR, 8'h00, 1'b0, 1'b0, 8'h00);
        pat = 8'hB2;
        kick("ser_start", USR_SHL, 4'd8, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            sin_l = pat[8-i];
            rv = pat >> (8 - i);
            push(rv, (i < 8), (i == 8));
            tick("ser_step");
        end
        sin_l = 1'b0;
        check("ser_final", 32'(q), 32'hB2);

        // Back-to-back: second start accepted in the done cycle of the first
        kick("b2b_first", USR_ROTL, 4'd1, 8'hB2);
        push(8'h65, 1'b0, 1'b1); tick("b2b_first_done");
        sin_r = 1'b1;
        kick("b2b_second", USR_SHR, 4'd2, 8'h65);
        push(8'hB2, 1'b1, 1'b0); tick("b2b_s1");
        push(8'hD9, 1'b0, 1'b1); tick("b2b_s2");
        push(8'hD9, 1'b0, 1'b0); tick("b2b_after");
        sin_r = 1'b0;

        // Reset on the third step of a shl by 5 aborts with no done pulse
        single("ld0f", USR_LOAD, 8'h0F, 1'b0, 1'b0, 8'h0F);
        kick("abort_start", USR_SHL, 4'd5, 8'h0F);
        push(8'h1E, 1'b1, 1'b0); tick("abort_s1");
        push(8'h3C, 1'b1, 1'b0); tick("abort_s2");
        reset = 1'b1;
        push(8'h00, 1'b0, 1'b0); tick("abort_rst");
        reset = 1'b0;
        push(8'h00, 1'b0, 1'b0); tick("abort_post1");
        push(8'h00, 1'b0, 1'b0); tick("abort_post2");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
